// File: rtl/gfx_cmd_pkg.sv
// gfx_cmd_pkg
// Shared definitions for the graphics command path: the instruction word
// width and field layout, opcode values, the default inter-byte timeout,
// and the state type used by the UART command assembler.
package gfx_cmd_pkg;

  localparam int CMD_WIDTH = 24;

  // Field layout of an instruction word
  localparam int OPCODE_MSB = 23;
  localparam int OPCODE_LSB = 20;
  localparam int COLOUR_MSB = 19;
  localparam int COLOUR_LSB = 17;
  localparam int ADDR_MSB   = 16;
  localparam int ADDR_LSB   = 0;

  localparam logic [3:0] OP_ECHO   = 4'd1;
  localparam logic [3:0] OP_PUT    = 4'd2;
  localparam logic [3:0] OP_STREAM = 4'd3;
  localparam logic [3:0] OP_CLEAR  = 4'd4;

  // 5 ms at 100 MHz between bytes of one frame
  localparam int DEFAULT_TIMEOUT_CYCLES = 500_000;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  colour;
    logic [16:0] addr;
  } gfx_cmd_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_RECOVER = 1'b1
  } asm_state_t;

  function automatic logic [3:0] cmdOpcode(input logic [CMD_WIDTH-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Synchronous first-word-fall-through queue for instruction words.
// A push while full is accepted when a pop happens in the same cycle.
// While empty, o_Data keeps showing the last head word so the consumer
// side never sees stale memory contents.
//
// Ports:
//   i_Clk, i_Rst   clock, synchronous active-high reset
//   i_Clear        synchronous clear of all queued words
//   i_Push         write i_PushData (dropped if full and no pop)
//   i_Pop          remove the head word (ignored while empty)
//   o_Data         head word, held while empty
//   o_Full/o_Empty occupancy flags
module cmd_fifo
  import gfx_cmd_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Clear,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_PushData,
  input  logic             i_Pop,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_hold;

  logic w_full;
  logic w_empty;
  logic w_doPop;
  logic w_doPush;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_doPop  = i_Pop && !w_empty;
  assign w_doPush = i_Push && (!w_full || w_doPop);

  assign o_Full  = w_full;
  assign o_Empty = w_empty;
  assign o_Data  = w_empty ? r_hold : r_mem[r_rdPtr];

  // Storage array; no reset needed since occupancy tracks valid entries
  always_ff @(posedge i_Clk) begin
    if (!i_Rst && !i_Clear && w_doPush) begin
      r_mem[r_wrPtr] <= i_PushData;
    end
  end

  // Pointers, occupancy and the held head word. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (!w_empty) begin
        r_hold <= r_mem[r_rdPtr];
      end
      if (i_Clear) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_doPush) begin
          r_wrPtr <= r_wrPtr + 1'b1;
        end
        if (w_doPop) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
        case ({w_doPush, w_doPop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler
// Packs bytes from the UART receiver into instruction words (first byte in
// the most significant position) and queues complete words for the
// graphics executor. A partial frame is discarded on an inter-byte timeout
// or on a receiver error; in both cases the receiver is reset with a
// one-cycle low pulse on o_RxResetN. A full queue only drops the word.
//
// Ports:
//   i_Clk, i_Rst      clock, synchronous active-high reset
//   i_RxData/Ready    received byte and its one-cycle strobe
//   i_RxError         receiver framing error
//   o_RxEnable        receiver enable (high once out of reset)
//   o_RxResetN        active-low receiver reset
//   i_Flush           clear partial frame and queue, counters kept
//   o_CmdData/Valid   head-of-queue word, queue not empty
//   i_CmdReady        consumer accepts head word
//   o_PartialBusy     a frame is partially collected
//   o_DropCount       words lost to a full queue (saturating)
//   o_TimeoutCount    partial frames lost to timeout (saturating)
//   o_ErrorCount      partial frames lost to receiver error (saturating)
module uart_cmd_assembler
  import gfx_cmd_pkg::*;
#(
  parameter int CMD_BYTES      = CMD_WIDTH / 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [7:0]             i_RxData,
  input  logic                   i_RxReady,
  input  logic                   i_RxError,
  output logic                   o_RxEnable,
  output logic                   o_RxResetN,
  input  logic                   i_Flush,
  output logic [8*CMD_BYTES-1:0] o_CmdData,
  output logic                   o_CmdValid,
  input  logic                   i_CmdReady,
  output logic                   o_PartialBusy,
  output logic [CNT_WIDTH-1:0]   o_DropCount,
  output logic [CNT_WIDTH-1:0]   o_TimeoutCount,
  output logic [CNT_WIDTH-1:0]   o_ErrorCount
);

  localparam int WORD_W  = 8 * CMD_BYTES;
  localparam int SHIFT_W = 8 * (CMD_BYTES - 1);
  localparam int IDX_W   = $clog2(CMD_BYTES);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(CMD_BYTES - 1);
  // The idle cycle seen with the timer at this value is the one that
  // takes it to TIMEOUT_CYCLES-1, so the frame is dropped on that cycle.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);

  asm_state_t         r_state;
  logic [IDX_W-1:0]   r_byteIdx;
  logic [TIMER_W-1:0] r_timer;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_rxEnable;
  logic               r_rxResetN;
  logic [CNT_WIDTH-1:0] r_dropCount;
  logic [CNT_WIDTH-1:0] r_timeoutCount;
  logic [CNT_WIDTH-1:0] r_errorCount;

  logic              w_partialBusy;
  logic              w_timeout;
  logic              w_pushReq;
  logic              w_pop;
  logic              w_drop;
  logic [WORD_W-1:0] w_word;
  logic              w_fifoFull;
  logic              w_fifoEmpty;

  assign w_partialBusy = (r_byteIdx != '0);
  assign w_timeout     = w_partialBusy && !i_RxReady && (r_timer == TIMER_LAST);

  // The earlier bytes sit in the shift register; the last byte goes
  // straight into the word so it is pushed in the cycle it arrives.
  assign w_word    = {r_shift, i_RxData};
  assign w_pushReq = (r_state == ST_COLLECT) && !i_Flush && !i_RxError &&
                     i_RxReady && (r_byteIdx == IDX_LAST);
  assign w_pop     = i_CmdReady && !w_fifoEmpty;
  assign w_drop    = w_pushReq && w_fifoFull && !w_pop;

  cmd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clear    (i_Flush),
    .i_Push     (w_pushReq),
    .i_PushData (w_word),
    .i_Pop      (i_CmdReady),
    .o_Data     (o_CmdData),
    .o_Full     (w_fifoFull),
    .o_Empty    (w_fifoEmpty)
  );

  // Frame collection and recovery. Event priority inside COLLECT is
  // flush, receiver error, timeout, then byte capture. RECOVER lasts one
  // cycle with the receiver held in reset and all input bytes ignored.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state        <= ST_COLLECT;
      r_byteIdx      <= '0;
      r_timer        <= '0;
      r_shift        <= '0;
      r_rxEnable     <= 1'b0;
      r_rxResetN     <= 1'b0;
      r_dropCount    <= '0;
      r_timeoutCount <= '0;
      r_errorCount   <= '0;
    end else begin
      r_rxEnable <= 1'b1;
      r_rxResetN <= 1'b1;
      case (r_state)
        ST_RECOVER: begin
          r_state   <= ST_COLLECT;
          r_byteIdx <= '0;
          r_timer   <= '0;
        end
        ST_COLLECT: begin
          if (i_Flush) begin
            r_byteIdx <= '0;
            r_timer   <= '0;
          end else if (i_RxError) begin
            r_byteIdx  <= '0;
            r_timer    <= '0;
            r_state    <= ST_RECOVER;
            r_rxResetN <= 1'b0;
            if (r_errorCount != '1) begin
              r_errorCount <= r_errorCount + 1'b1;
            end
          end else if (w_timeout) begin
            r_byteIdx  <= '0;
            r_timer    <= '0;
            r_state    <= ST_RECOVER;
            r_rxResetN <= 1'b0;
            if (r_timeoutCount != '1) begin
              r_timeoutCount <= r_timeoutCount + 1'b1;
            end
          end else if (i_RxReady) begin
            r_shift <= SHIFT_W'({r_shift, i_RxData});
            r_timer <= '0;
            if (r_byteIdx == IDX_LAST) begin
              r_byteIdx <= '0;
              if (w_drop && (r_dropCount != '1)) begin
                r_dropCount <= r_dropCount + 1'b1;
              end
            end else begin
              r_byteIdx <= r_byteIdx + 1'b1;
            end
          end else if (w_partialBusy) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign o_RxEnable     = r_rxEnable;
  assign o_RxResetN     = r_rxResetN;
  assign o_CmdValid     = !w_fifoEmpty;
  assign o_PartialBusy  = w_partialBusy;
  assign o_DropCount    = r_dropCount;
  assign o_TimeoutCount = r_timeoutCount;
  assign o_ErrorCount   = r_errorCount;

endmodule
